mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that lets a running program send bytes out on the board `tx` pin, the outbound counterpart to the UART programming receiver. It sits on the MEM-stage IO bus beside `MEM_IO`. The CPU writes bytes into a small FIFO, and the block serializes them as 8N1 frames at a fixed divisor of the CPU clock. A status word is readable so software can poll for space before writing.

---
 rtl/mmio_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a small FIFO on the
// MEM-stage IO bus, and a bit-timed FSM serializes them LSB first on tx.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] DATA_ADDR    = 32'hFFFF_FC70,
  parameter logic [31:0] STAT_ADDR    = 32'hFFFF_FC74
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_we,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_data,
  output logic [31:0] io_read_data,
  output logic        tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULLV = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  state_t        r_state;
  logic [BW-1:0] r_bcnt;
  logic [2:0]    r_bidx;
  logic [7:0]    r_sh;
  logic          r_tx;

  logic       w_push_req;
  logic       w_clr_req;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_drop;
  logic       w_bit_end;
  logic       w_pop;
  logic [7:0] w_head;
  logic [7:0] w_cnt8;
  logic       w_unused;

  assign w_push_req = io_we && (io_addr == DATA_ADDR);
  assign w_clr_req  = io_we && (io_addr == STAT_ADDR);
  assign w_full     = (r_count == FULLV);
  assign w_empty    = (r_count == '0);
  // Full is judged on the start-of-cycle count, so a pop this cycle never rescues a push.
  assign w_push     = w_push_req && !w_full;
  assign w_drop     = w_push_req && w_full;
  assign w_bit_end  = (r_bcnt == BLAST);
  assign w_pop      = !w_empty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head     = r_mem[r_rptr];
  assign w_cnt8     = 8'(r_count);
  assign w_unused   = ^io_data[31:8];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= io_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_clr_req) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_sh    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_sh    <= w_head;
            r_bcnt  <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_tx    <= r_sh[0];
            r_state <= S_DATA;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bcnt <= '0;
            r_sh   <= r_sh >> 1;
            if (r_bidx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bidx <= r_bidx + 3'd1;
              r_tx   <= r_sh[1];
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_bcnt <= '0;
            // Queued data starts the next frame straight out of the stop bit.
            if (w_pop) begin
              r_sh    <= w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx = r_tx;

  assign io_read_data = (io_addr == STAT_ADDR)
                      ? {16'h0, w_cnt8, 4'h0, r_ovf, (r_state != S_IDLE), w_empty, w_full}
                      : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue-based line/FIFO reference model, a UART receiver
// that decodes tx, directed scenarios and a randomized traffic phase.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] DA    = 32'hFFFF_FC70;
  localparam logic [31:0] SA    = 32'hFFFF_FC74;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_we = 1'b0;
  logic [31:0] io_addr = 32'h0;
  logic [31:0] io_data = 32'h0;
  logic [31:0] io_read_data;
  logic        tx;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .DATA_ADDR   (DA),
    .STAT_ADDR   (SA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_data     (io_data),
    .io_read_data(io_read_data),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Reference model: pending bytes, the expected line waveform and bytes in flight.
  logic [7:0] m_q[$];
  bit         m_line[$];
  logic [7:0] m_frm[$];
  bit         m_tx   = 1'b1;
  bit         m_busy = 1'b0;
  bit         m_ovf  = 1'b0;

  task automatic model_step();
    int         sz0;
    logic [7:0] b;
    if (rst) begin
      m_q.delete(); m_line.delete(); m_frm.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_ovf = 1'b0;
      return;
    end
    sz0 = m_q.size();
    if (m_line.size() == 0 && sz0 != 0) begin
      b = m_q.pop_front();
      m_frm.push_back(b);
      for (int i = 0; i < CPB; i++) m_line.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < CPB; i++) m_line.push_back(b[k]);
      for (int i = 0; i < CPB; i++) m_line.push_back(1'b1);
    end
    m_busy = (m_line.size() != 0);
    m_tx   = (m_line.size() != 0) ? m_line.pop_front() : 1'b1;
    if (io_we && io_addr == DA) begin
      if (sz0 == DEPTH) m_ovf = 1'b1;
      else              m_q.push_back(io_data[7:0]);
    end else if (io_we && io_addr == SA) begin
      m_ovf = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_stat();
    int s;
    s = m_q.size();
    return {16'h0, 8'(s), 4'h0, m_ovf, m_busy, (s == 0), (s == DEPTH)};
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_line", {31'b0, tx}, {31'b0, m_tx});
      chk("read_data", io_read_data, (io_addr == SA) ? m_stat() : 32'h0);
    end
  end

  // Receiver: samples each bit mid-period after a detected falling edge.
  int         rx_cnt = -1;
  logic [9:0] rx_bits;
  logic [7:0] rxq[$];

  task automatic rx_step();
    int         k;
    logic [7:0] b;
    logic [31:0] exp;
    if (rst || !chk_en) begin
      rx_cnt = -1;
      return;
    end
    if (rx_cnt < 0) begin
      if (tx == 1'b0) rx_cnt = 0;
      else return;
    end else begin
      rx_cnt++;
    end
    if (rx_cnt % CPB == CPB / 2) begin
      k = rx_cnt / CPB;
      rx_bits[k] = tx;
      if (k == 0) chk("rx_start", {31'b0, tx}, 32'h0);
      if (k == 9) begin
        b = rx_bits[8:1];
        chk("rx_stop", {31'b0, tx}, 32'h1);
        exp = (m_frm.size() != 0) ? {24'h0, m_frm.pop_front()} : 32'hDEAD_0000;
        chk("rx_byte", {24'h0, b}, exp);
        rxq.push_back(b);
        rx_cnt = -1;
      end
    end
  endtask

  always @(negedge clk) rx_step();

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_we = 1'b1; io_addr = a; io_data = d;
    @(posedge clk); #1;
    io_we = 1'b0; io_addr = SA;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_stat(input string tag, input logic [31:0] exp);
    io_addr = SA;
    #1;
    chk(tag, io_read_data, exp);
  endtask

  task automatic chk_rx(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_n"}, rxq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rxq.size(); i++)
      chk(tag, {24'h0, rxq[i]}, {24'h0, exp[i]});
  endtask

  initial begin
    int r;
    io_addr = SA;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;

    // Reset values and idle line
    rd_stat("rst_stat", 32'h0000_0002);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    idle(100);
    chk("idle_tx", {31'b0, tx}, 32'h1);

    // Single byte
    rxq.delete();
    wr(DA, 32'h0000_00A5);
    rd_stat("push_count", 32'h0000_0100);
    idle(1);
    rd_stat("start_busy", 32'h0000_0006);
    chk("start_tx", {31'b0, tx}, 32'h0);
    idle(40);
    rd_stat("single_done", 32'h0000_0002);
    chk_rx("single_rx", '{8'hA5});

    // Back-to-back
    rxq.delete();
    wr(DA, 32'h01); wr(DA, 32'h02); wr(DA, 32'h03);
    rd_stat("b2b_cnt2", 32'h0000_0204);
    idle(39);
    rd_stat("b2b_cnt1", 32'h0000_0104);
    idle(40);
    rd_stat("b2b_cnt0", 32'h0000_0006);
    idle(40);
    rd_stat("b2b_done", 32'h0000_0002);
    chk_rx("b2b_rx", '{8'h01, 8'h02, 8'h03});

    // Overflow with a byte in flight
    rxq.delete();
    wr(DA, 32'h10);
    for (int i = 1; i <= 5; i++) wr(DA, 32'h10 + i);
    rd_stat("ovf_stat", 32'h0000_040D);
    wr(SA, 32'h0);
    rd_stat("ovf_clear", 32'h0000_0405);
    idle(200);
    chk_rx("ovf_rx", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});

    // Full FIFO with a push on the pop edge
    rxq.delete();
    wr(DA, 32'h20);
    for (int i = 1; i <= 4; i++) wr(DA, 32'h20 + i);
    idle(36);
    wr(DA, 32'h25);
    rd_stat("fullpop_stat", 32'h0000_030C);
    wr(SA, 32'h0);
    idle(165);
    chk_rx("fullpop_rx", '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24});

    // Reset mid-frame during data bit 3
    rxq.delete();
    wr(DA, 32'h30); wr(DA, 32'h31); wr(DA, 32'h32);
    idle(15);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_tx", {31'b0, tx}, 32'h1);
    rd_stat("midrst_stat", 32'h0000_0002);
    idle(100);
    chk("midrst_rx_n", rxq.size(), 0);
    chk("midrst_tx_idle", {31'b0, tx}, 32'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      wr(DA, $urandom);
      else if (r < 34) wr(SA, $urandom);
      else if (r < 37) wr($urandom, $urandom);
      else if (r < 38) begin
        rst = 1'b1; idle(1); rst = 1'b0;
      end else begin
        io_addr = ($urandom_range(0, 3) == 0) ? $urandom : SA;
        idle(1);
      end
    end
    io_addr = SA;
    idle(400);
    rd_stat("final_stat", 32'h0000_0002 | (m_ovf ? 32'h8 : 32'h0));
    chk("final_frames_left", m_frm.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
